// File: rtl/vector_replay_misr.sv
// Replays a stored list of stimulus words into a DUT and compacts every absorbed
// response cycle into a MISR signature that is compared against an expected value.
module vector_replay_misr #(
    parameter int              IN_W  = 79,
    parameter int              OUT_W = 501,
    parameter int              DEPTH = 32,
    parameter int              HOLD  = 1,
    parameter int              LAT   = 0,
    parameter int              SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [IN_W-1:0]  ld_data,
    input  logic             start,
    input  logic             abort,
    input  logic             loop_mode,
    output logic [IN_W-1:0]  stim,
    output logic             stim_valid,
    input  logic [OUT_W-1:0] dut_y,
    input  logic [SIG_W-1:0] exp_sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW  = $clog2(DEPTH + 1);
    localparam int HW  = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int DW  = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int NCH = (OUT_W + SIG_W - 1) / SIG_W;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [DW-1:0] LAT_LAST  = DW'((LAT > 0) ? LAT - 1 : 0);
    localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
    localparam logic [AW-1:0] ADDR0     = '0;
    localparam bit            NO_DRAIN  = (LAT == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // XOR of the response cut into SIG_W chunks, top chunk zero-padded
    function automatic logic [SIG_W-1:0] fold_y(input logic [OUT_W-1:0] y);
        logic [NCH*SIG_W-1:0] pad;
        logic [SIG_W-1:0]     acc;
        pad            = '0;
        pad[OUT_W-1:0] = y;
        acc            = '0;
        for (int i = 0; i < NCH; i++) begin
            acc = acc ^ pad[i*SIG_W +: SIG_W];
        end
        return acc;
    endfunction

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                   input logic [SIG_W-1:0] f);
        logic [SIG_W-1:0] fb;
        fb = s[SIG_W-1] ? POLY : '0;
        return {s[SIG_W-2:0], 1'b0} ^ fb ^ f;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [IN_W-1:0]   mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [HW-1:0]     hold_r;
    logic [DW-1:0]     drain_r;
    logic [IN_W-1:0]   stim_r;
    logic              stim_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              pass_r;
    logic [SIG_W-1:0]  sig_r;

    logic              ld_ready_s;
    logic              clr_s;
    logic              accept_s;
    logic [PW-1:0]     count_s;
    logic [IN_W-1:0]   first_word_s;
    logic [SIG_W-1:0]  sig_next_s;
    logic              hold_last_s;
    logic              rd_last_s;
    logic              drain_last_s;
    logic              run_end_s;

    assign ld_ready_s   = (state_r == S_IDLE) && (wr_ptr_r < DEPTH_P);
    // start takes precedence over clr; clr takes precedence over a load
    assign clr_s        = clr && !start && (state_r == S_IDLE);
    assign accept_s     = ld_valid && ld_ready_s && !clr_s;
    assign count_s      = wr_ptr_r + {{(PW-1){1'b0}}, accept_s};
    // a word accepted into an empty memory on the start edge is not in mem_r yet
    assign first_word_s = (wr_ptr_r == '0) ? ld_data : mem_r[ADDR0];
    assign sig_next_s   = misr_step(sig_r, fold_y(dut_y));
    assign hold_last_s  = (hold_r == HOLD_LAST);
    assign rd_last_s    = (PW'(rd_ptr_r) == (wr_ptr_r - PW'(1)));
    assign drain_last_s = (drain_r == LAT_LAST);
    assign run_end_s    = hold_last_s && rd_last_s && !loop_mode;

    // next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (count_s != '0) begin
                        state_nxt_s = S_RUN;
                    end else begin
                        state_nxt_s = S_DONE;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt_s = S_IDLE;
                end else if (run_end_s) begin
                    state_nxt_s = NO_DRAIN ? S_DONE : S_DRAIN;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_nxt_s = S_IDLE;
                end else if (drain_last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // stimulus memory write port; contents are not reset
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= ld_data;
        end
    end

    // replay pointers, stimulus register, MISR and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            hold_r       <= '0;
            drain_r      <= '0;
            stim_r       <= '0;
            stim_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            sig_r        <= '0;
        end else begin
            if (clr_s) begin
                wr_ptr_r <= '0;
            end else if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        sig_r <= SEED;
                        if (count_s != '0) begin
                            rd_ptr_r <= '0;
                            hold_r   <= '0;
                            stim_r   <= first_word_s;
                            pass_r   <= 1'b0;
                        end else begin
                            pass_r <= (SEED == exp_sig);
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        pass_r <= 1'b0;
                    end else begin
                        sig_r <= sig_next_s;
                        if (hold_last_s) begin
                            hold_r <= '0;
                            if (!rd_last_s) begin
                                rd_ptr_r <= rd_ptr_r + AW'(1);
                                stim_r   <= mem_r[rd_ptr_r + AW'(1)];
                            end else if (loop_mode) begin
                                rd_ptr_r <= '0;
                                stim_r   <= mem_r[ADDR0];
                            end else begin
                                drain_r <= '0;
                                if (NO_DRAIN) begin
                                    pass_r <= (sig_next_s == exp_sig);
                                end
                            end
                        end else begin
                            hold_r <= hold_r + HW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        pass_r <= 1'b0;
                    end else begin
                        sig_r   <= sig_next_s;
                        drain_r <= drain_r + DW'(1);
                        if (drain_last_s) begin
                            pass_r <= (sig_next_s == exp_sig);
                        end
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
            stim_valid_r <= (state_nxt_s == S_RUN);
            busy_r       <= (state_nxt_s == S_RUN) || (state_nxt_s == S_DRAIN);
            done_r       <= (state_nxt_s == S_DONE);
        end
    end

    assign ld_ready   = ld_ready_s;
    assign stim       = stim_r;
    assign stim_valid = stim_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign signature  = sig_r;

endmodule
